// File: rtl/ropuf_seq_engine_if.sv
// RO-PUF sequencer request/response bundle: challenge in, response/unstable out.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while the engine is idle (busy=0, done=0).
//
// Ports (signals):
//   start      request strobe, sampled by the engine only in IDLE
//   challenge  N_BITS pairs of {down_sel, up_sel}, SEL_W bits each
//   busy       engine is measuring (SETTLE/MEASURE/COMPARE)
//   done       one-cycle completion pulse
//   response   one bit per pair, 1 when the up RO counted more edges
//   unstable   one bit per pair, 1 when the counts were too close (or same RO)
interface ropuf_seq_engine_if #(
   parameter int N_RO   = 16,
   parameter int N_BITS = 16
);
   localparam int SEL_W = (N_RO > 1) ? $clog2(N_RO) : 1;

   logic                      start;
   logic [N_BITS*2*SEL_W-1:0] challenge;
   logic                      busy;
   logic                      done;
   logic [N_BITS-1:0]         response;
   logic [N_BITS-1:0]         unstable;

   modport master (
      output start, challenge,
      input  busy, done, response, unstable
   );

   modport slave (
      input  start, challenge,
      output busy, done, response, unstable
   );
endinterface

// File: rtl/ropuf_seq_engine.sv
// RO-PUF measurement sequencer: per response bit, runs one RO pair, counts edges, compares.
// Latency: done in cycle k+1+N_BITS*(SETTLE_CYCLES+WIN_CYCLES+1) after start sampled at edge k.
// Backpressure: start ignored unless IDLE; latched challenge is immune to later input changes.
//
// Ports:
//   clk        system clock
//   Reset      synchronous, active-high reset (aborts a run, clears all results)
//   ro_div_in  divided RO outputs, asynchronous to clk
//   ro_enable  run enables for the selected RO pair (SETTLE/MEASURE only)
//   bus        request/response bundle (slave side)
module ropuf_seq_engine #(
   parameter int N_RO          = 16,
   parameter int N_BITS        = 16,
   parameter int CNT_W         = 16,
   parameter int WIN_CYCLES    = 255,
   parameter int SETTLE_CYCLES = 4,
   parameter int MARGIN        = 2
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic [N_RO-1:0]      ro_div_in,
   output logic [N_RO-1:0]      ro_enable,
   ropuf_seq_engine_if.slave    bus
);

   localparam int SEL_W = (N_RO > 1) ? $clog2(N_RO) : 1;
   localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int T_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int T_W   = $clog2(T_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t state_q, state_d;
   logic [T_W-1:0]   tmr_q, tmr_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Latched challenge: [bit][0]=up select, [bit][1]=down select.
   logic [N_BITS-1:0][1:0][SEL_W-1:0] chal_q;

   logic [N_RO-1:0]  sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0] up_cnt_q, dn_cnt_q;
   logic [N_BITS-1:0] resp_q, unst_q;

   logic [SEL_W-1:0] up_sel, dn_sel;
   logic             same_sel;
   logic             up_edge, dn_edge;
   logic [CNT_W:0]   diff;
   logic             resp_bit, unst_bit;

   // ---------------------------------------------------------------
   // Pair selection, edge detection and comparison
   // ---------------------------------------------------------------
   always_comb begin
      up_sel   = chal_q[idx_q][0];
      dn_sel   = chal_q[idx_q][1];
      same_sel = (up_sel == dn_sel);
      up_edge  = sync2_q[up_sel] & ~prev_q[up_sel];
      dn_edge  = sync2_q[dn_sel] & ~prev_q[dn_sel];
      if (up_cnt_q > dn_cnt_q)
         diff = {1'b0, up_cnt_q} - {1'b0, dn_cnt_q};
      else
         diff = {1'b0, dn_cnt_q} - {1'b0, up_cnt_q};
      // A pair measured against itself carries no entropy: force 0 and flag it.
      resp_bit = !same_sel && (up_cnt_q > dn_cnt_q);
      unst_bit = same_sel || (diff < (CNT_W+1)'(MARGIN));
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SETTLE;
               tmr_d   = '0;
               idx_d   = '0;
            end
         end
         S_SETTLE: begin
            if (tmr_q == T_W'(SETTLE_CYCLES - 1)) begin
               state_d = S_MEASURE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + T_W'(1);
            end
         end
         S_MEASURE: begin
            if (tmr_q == T_W'(WIN_CYCLES - 1)) begin
               state_d = S_COMPARE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + T_W'(1);
            end
         end
         S_COMPARE: begin
            if (idx_q == IDX_W'(N_BITS - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + IDX_W'(1);
               tmr_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // RO synchronisers: two flops for metastability, third is the edge reference
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= ro_div_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // ---------------------------------------------------------------
   // Edge counters, challenge latch and result registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (Reset) begin
         chal_q   <= '0;
         resp_q   <= '0;
         unst_q   <= '0;
         up_cnt_q <= '0;
         dn_cnt_q <= '0;
      end else begin
         if (state_q == S_IDLE && bus.start) begin
            chal_q <= bus.challenge;
            resp_q <= '0;
            unst_q <= '0;
         end
         if (state_q == S_COMPARE) begin
            resp_q[idx_q] <= resp_bit;
            unst_q[idx_q] <= unst_bit;
         end
         // Counters run only in MEASURE, hold through COMPARE for the
         // comparison, and sit at zero everywhere else.
         if (state_q == S_MEASURE) begin
            if (up_edge && up_cnt_q != CNT_MAX)
               up_cnt_q <= up_cnt_q + CNT_W'(1);
            if (dn_edge && dn_cnt_q != CNT_MAX)
               dn_cnt_q <= dn_cnt_q + CNT_W'(1);
         end else if (state_q != S_COMPARE) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs, all decoded from registered state
   // ---------------------------------------------------------------
   always_comb begin
      ro_enable = '0;
      if (state_q == S_SETTLE || state_q == S_MEASURE)
         ro_enable = (N_RO'(1) << up_sel) | (N_RO'(1) << dn_sel);
   end

   assign bus.busy     = (state_q == S_SETTLE) || (state_q == S_MEASURE) ||
                         (state_q == S_COMPARE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.response = resp_q;
   assign bus.unstable = unst_q;

endmodule

// File: tb/tb_ropuf_seq_engine.sv
// Self-checking bench for ropuf_seq_engine: scoreboarded runs on a short-window
// instance and a narrow-counter instance driven by free-running RO square waves.
module tb_ropuf_seq_engine;

   localparam int N_RO     = 4;
   localparam int N_BITS   = 2;
   localparam int SET      = 3;
   localparam int MARGIN   = 2;
   localparam int WIN_A    = 16;
   localparam int CNT_W_A  = 16;
   localparam int WIN_B    = 64;
   localparam int CNT_W_B  = 3;
   localparam int LAT_A    = 1 + N_BITS * (SET + WIN_A + 1);
   localparam int LAT_B    = 1 + N_BITS * (SET + WIN_B + 1);
   localparam int CAP_A    = (1 << CNT_W_A) - 1;
   localparam int CAP_B    = (1 << CNT_W_B) - 1;
   // Rising edges per window: RO0 period 4, RO1 period 8, RO2/RO3 period 6 in phase.
   localparam int EDGES_A [4] = '{4, 2, 3, 3};
   localparam int EDGES_B [4] = '{16, 8, 10, 10};

   typedef struct {
      logic [1:0] resp;
      logic [1:0] unst;
      int         done_cyc;
   } exp_t;

   logic       clk   = 1'b0;
   logic       Reset = 1'b1;
   logic       ro0   = 1'b0;
   logic       ro1   = 1'b0;
   logic       ro23  = 1'b0;
   logic [3:0] ro_div;
   logic [3:0] ro_en_a, ro_en_b;
   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   exp_t       sb[$];

   assign ro_div = {ro23, ro23, ro1, ro0};

   ropuf_seq_engine_if #(.N_RO(N_RO), .N_BITS(N_BITS)) bus_a ();
   ropuf_seq_engine_if #(.N_RO(N_RO), .N_BITS(N_BITS)) bus_b ();

   ropuf_seq_engine #(
      .N_RO(N_RO), .N_BITS(N_BITS), .CNT_W(CNT_W_A), .WIN_CYCLES(WIN_A),
      .SETTLE_CYCLES(SET), .MARGIN(MARGIN)
   ) dut_a (
      .clk(clk), .Reset(Reset), .ro_div_in(ro_div), .ro_enable(ro_en_a), .bus(bus_a)
   );

   ropuf_seq_engine #(
      .N_RO(N_RO), .N_BITS(N_BITS), .CNT_W(CNT_W_B), .WIN_CYCLES(WIN_B),
      .SETTLE_CYCLES(SET), .MARGIN(MARGIN)
   ) dut_b (
      .clk(clk), .Reset(Reset), .ro_div_in(ro_div), .ro_enable(ro_en_b), .bus(bus_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin #3; forever #20 ro0  = ~ro0;  end
   initial begin #3; forever #40 ro1  = ~ro1;  end
   initial begin #3; forever #30 ro23 = ~ro23; end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] mk_chal(input int u0, input int d0, input int u1, input int d1);
      logic [7:0] c;
      c = {2'(d1), 2'(u1), 2'(d0), 2'(u0)};
      return c;
   endfunction

   function automatic void model_run(input int u0, input int d0, input int u1, input int d1,
                                     input int e [4], input int cap,
                                     output logic [1:0] r, output logic [1:0] un);
      int us [2];
      int ds [2];
      us[0] = u0; ds[0] = d0; us[1] = u1; ds[1] = d1;
      for (int i = 0; i < 2; i++) begin
         int eu, ed, d;
         eu = (e[us[i]] > cap) ? cap : e[us[i]];
         ed = (e[ds[i]] > cap) ? cap : e[ds[i]];
         d  = (eu > ed) ? eu - ed : ed - eu;
         if (us[i] == ds[i]) begin
            r[i]  = 1'b0;
            un[i] = 1'b1;
         end else begin
            r[i]  = (eu > ed);
            un[i] = (d < MARGIN);
         end
      end
   endfunction

   // Drive one accepted start on the short-window instance and queue its expectation.
   task automatic launch_a(input int u0, input int d0, input int u1, input int d1, output int k);
      logic [1:0] r, un;
      exp_t e;
      model_run(u0, d0, u1, d1, EDGES_A, CAP_A, r, un);
      @(negedge clk);
      bus_a.challenge = mk_chal(u0, d0, u1, d1);
      bus_a.start     = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      k = cyc;
      e.resp = r; e.unst = un; e.done_cyc = k + LAT_A - 1;
      sb.push_back(e);
   endtask

   // Observe ncyc cycles; report how many done pulses occurred and the first one.
   task automatic watch_a(input int ncyc, output int ndone, output int first_cyc,
                          output logic [1:0] r_at, output logic [1:0] u_at);
      ndone = 0; first_cyc = -1; r_at = '0; u_at = '0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) begin
            if (ndone == 0) begin
               first_cyc = cyc;
               r_at = bus_a.response;
               u_at = bus_a.unstable;
            end
            ndone++;
         end
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      bus_a.start = 1'b0; bus_a.challenge = '0;
      bus_b.start = 1'b0; bus_b.challenge = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({bus_a.busy, bus_a.done, bus_a.response, bus_a.unstable, ro_en_a} !== 10'd0) begin
         bad++;
         $display("FAIL reset_a: got %b want 0", {bus_a.busy, bus_a.done, bus_a.response, bus_a.unstable, ro_en_a});
      end
      total++;
      if ({bus_b.busy, bus_b.done, bus_b.response, bus_b.unstable, ro_en_b} !== 10'd0) begin
         bad++;
         $display("FAIL reset_b: got %b want 0", {bus_b.busy, bus_b.done, bus_b.response, bus_b.unstable, ro_en_b});
      end
      Reset = 1'b0;
   endtask

   task automatic test_basic;
      int k, rel, ndone;
      logic [1:0] r_at, u_at;
      exp_t e;
      ndone = 0; r_at = '0; u_at = '0; rel = 0;
      launch_a(0, 1, 1, 0, k);
      for (int i = 0; i < LAT_A + 4; i++) begin
         @(negedge clk);
         rel = cyc - k + 1;
         total++;
         if (bus_a.busy !== ((rel >= 1) && (rel <= LAT_A - 1))) begin
            bad++;
            $display("FAIL basic_busy cycle %0d: got %b want %b", rel, bus_a.busy, (rel >= 1) && (rel <= LAT_A - 1));
         end
         if (rel == 1 || rel == 10 || rel == 30) begin
            total++;
            if (ro_en_a !== 4'b0011) begin
               bad++;
               $display("FAIL basic_ro_en cycle %0d: got %b want 0011", rel, ro_en_a);
            end
         end
         if (rel == SET + WIN_A + 1) begin
            total++;
            if (ro_en_a !== 4'b0000) begin
               bad++;
               $display("FAIL basic_ro_en_compare: got %b want 0000", ro_en_a);
            end
         end
         if (bus_a.done === 1'b1) begin
            if (ndone == 0) begin
               r_at = bus_a.response;
               u_at = bus_a.unstable;
               total++;
               if (rel != LAT_A) begin
                  bad++;
                  $display("FAIL basic_done_cycle: got %0d want %0d", rel, LAT_A);
               end
            end
            ndone++;
         end
      end
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL basic_done_count: got %0d want 1", ndone);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if ({r_at, u_at} !== {e.resp, e.unst}) begin
            bad++;
            $display("FAIL basic_result: got resp=%b unst=%b want resp=%b unst=%b", r_at, u_at, e.resp, e.unst);
         end
      end
   endtask

   task automatic test_equal_pair;
      int k, ndone, at;
      logic [1:0] r_at, u_at;
      exp_t e;
      launch_a(2, 3, 3, 2, k);
      watch_a(LAT_A + 5, ndone, at, r_at, u_at);
      e = sb.pop_front();
      total++;
      if (ndone != 1 || at != e.done_cyc) begin
         bad++;
         $display("FAIL equal_done: got count=%0d cyc=%0d want count=1 cyc=%0d", ndone, at, e.done_cyc);
      end
      total++;
      if ({r_at, u_at} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL equal_result: got resp=%b unst=%b want resp=%b unst=%b", r_at, u_at, e.resp, e.unst);
      end
   endtask

   task automatic test_same_sel;
      int k, ndone, at;
      logic [1:0] r_at, u_at;
      exp_t e;
      launch_a(1, 1, 0, 1, k);
      watch_a(LAT_A + 5, ndone, at, r_at, u_at);
      e = sb.pop_front();
      total++;
      if (ndone != 1 || at != e.done_cyc) begin
         bad++;
         $display("FAIL same_sel_done: got count=%0d cyc=%0d want count=1 cyc=%0d", ndone, at, e.done_cyc);
      end
      total++;
      if ({r_at, u_at} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL same_sel_result: got resp=%b unst=%b want resp=%b unst=%b", r_at, u_at, e.resp, e.unst);
      end
   endtask

   task automatic test_start_ignored;
      int k, ndone, at;
      logic [1:0] r_at, u_at;
      exp_t e;
      launch_a(0, 1, 1, 0, k);
      for (int i = 0; i < 20 && cyc < k + 9; i++) @(negedge clk);
      bus_a.challenge = mk_chal(1, 0, 0, 1);
      bus_a.start     = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      watch_a(LAT_A + 15, ndone, at, r_at, u_at);
      e = sb.pop_front();
      total++;
      if (ndone != 1 || at != e.done_cyc) begin
         bad++;
         $display("FAIL ignored_start_done: got count=%0d cyc=%0d want count=1 cyc=%0d", ndone, at, e.done_cyc);
      end
      total++;
      if ({r_at, u_at} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL ignored_start_result: got resp=%b unst=%b want resp=%b unst=%b", r_at, u_at, e.resp, e.unst);
      end
   endtask

   task automatic test_reset_mid;
      int k, ndone, at;
      logic [1:0] r_at, u_at;
      exp_t e;
      launch_a(0, 1, 1, 0, k);
      // Cycle 30 lies inside the bit-1 measurement window; bit 0 is already written.
      for (int i = 0; i < 40 && cyc < k + 29; i++) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      total++;
      if ({bus_a.busy, bus_a.done, bus_a.response, bus_a.unstable, ro_en_a} !== 10'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got %b want 0", {bus_a.busy, bus_a.done, bus_a.response, bus_a.unstable, ro_en_a});
      end
      Reset = 1'b0;
      void'(sb.pop_back());
      watch_a(6, ndone, at, r_at, u_at);
      total++;
      if (ndone != 0 || bus_a.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_idle: got done_count=%0d busy=%b want 0 0", ndone, bus_a.busy);
      end
      launch_a(2, 3, 0, 1, k);
      watch_a(LAT_A + 5, ndone, at, r_at, u_at);
      e = sb.pop_front();
      total++;
      if (ndone != 1 || at != e.done_cyc) begin
         bad++;
         $display("FAIL reset_mid_rerun_done: got count=%0d cyc=%0d want count=1 cyc=%0d", ndone, at, e.done_cyc);
      end
      total++;
      if ({r_at, u_at} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL reset_mid_rerun_result: got resp=%b unst=%b want resp=%b unst=%b", r_at, u_at, e.resp, e.unst);
      end
   endtask

   task automatic test_back_to_back;
      int k, k2, ndone, at;
      logic [1:0] r_at, u_at;
      logic [1:0] r2, u2;
      exp_t e, e2;
      launch_a(1, 0, 0, 1, k);
      for (int i = 0; i < LAT_A + 5 && cyc < k + LAT_A - 1; i++) @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus_a.done !== 1'b1 || {bus_a.response, bus_a.unstable} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL b2b_first: got done=%b resp=%b unst=%b want done=1 resp=%b unst=%b",
                  bus_a.done, bus_a.response, bus_a.unstable, e.resp, e.unst);
      end
      // Start held from the DONE cycle: the DONE edge must ignore it, IDLE accepts it.
      model_run(2, 3, 3, 2, EDGES_A, CAP_A, r2, u2);
      bus_a.challenge = mk_chal(2, 3, 3, 2);
      bus_a.start     = 1'b1;
      @(negedge clk);
      total++;
      if (bus_a.busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_start_in_done: got busy=%b want 0", bus_a.busy);
      end
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      k2 = cyc;
      e2.resp = r2; e2.unst = u2; e2.done_cyc = k2 + LAT_A - 1;
      sb.push_back(e2);
      watch_a(LAT_A + 5, ndone, at, r_at, u_at);
      e = sb.pop_front();
      total++;
      if (ndone != 1 || at != e.done_cyc || {r_at, u_at} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL b2b_second: got count=%0d cyc=%0d resp=%b unst=%b want 1 %0d %b %b",
                  ndone, at, r_at, u_at, e.done_cyc, e.resp, e.unst);
      end
   endtask

   task automatic test_saturation;
      int k, ndone, at;
      logic [1:0] r, un, r_at, u_at;
      exp_t e;
      ndone = 0; at = -1; r_at = '0; u_at = '0;
      // RO0 (16 edges) vs RO2 (~10 edges): both clip at 7, so the pair reads equal.
      model_run(0, 2, 2, 0, EDGES_B, CAP_B, r, un);
      @(negedge clk);
      bus_b.challenge = mk_chal(0, 2, 2, 0);
      bus_b.start     = 1'b1;
      @(posedge clk);
      #1;
      bus_b.start = 1'b0;
      k = cyc;
      e.resp = r; e.unst = un; e.done_cyc = k + LAT_B - 1;
      sb.push_back(e);
      for (int i = 0; i < LAT_B + 5; i++) begin
         @(negedge clk);
         if (bus_b.done === 1'b1) begin
            if (ndone == 0) begin
               at = cyc; r_at = bus_b.response; u_at = bus_b.unstable;
            end
            ndone++;
         end
      end
      e = sb.pop_front();
      total++;
      if (ndone != 1 || at != e.done_cyc) begin
         bad++;
         $display("FAIL sat_done: got count=%0d cyc=%0d want count=1 cyc=%0d", ndone, at, e.done_cyc);
      end
      total++;
      if ({r_at, u_at} !== {e.resp, e.unst}) begin
         bad++;
         $display("FAIL sat_result: got resp=%b unst=%b want resp=%b unst=%b", r_at, u_at, e.resp, e.unst);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_equal_pair();
      test_same_sel();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
